// File: rtl/ft232h_pkg.sv
// Shared definitions for the FT232H synchronous-FIFO fetch engine.
package ft232h_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ADDR  = 3'd1,
    ST_WAIT_RXF = 3'd2,
    ST_RD_DATA  = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  // Address bytes sent to the device, data bytes returned, and strobe length
  // of the read burst (one turnaround cycle plus one cycle per data byte).
  localparam int ADDR_BYTES = 8;
  localparam int DATA_BYTES = 8;
  localparam int RD_CYCLES  = 9;

  // Byte idx of a 64-bit word, byte 0 in [7:0].
  function automatic logic [7:0] get_byte(input logic [63:0] w, input logic [2:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ft232h_fetch.sv
// Fetches one 64-bit word through an FT232H in synchronous FIFO mode:
// writes the 8-byte address LSB-first, waits for the device to report read
// data, strobes out 8 data bytes and returns them as a single response.
//
// Handshakes: a request transfers at a rising edge where req_valid and
// req_ready are both high; req_ready is high only while idle. rsp_valid is a
// one-cycle pulse with no backpressure, qualified by rsp_err on timeout.
module ft232h_fetch
  import ft232h_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  input  logic [7:0]  adbus_i,
  output logic [7:0]  adbus_o,
  output logic        adbus_oe,
  input  logic        txe_n,
  output logic        wr_n,
  output logic        siwu_n,
  input  logic        rxf_n,
  output logic        oe_n,
  output logic        rd_n,
  output logic [2:0]  dbg_state
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t                          state;
  logic [63:0]                     addr_q;
  logic [3:0]                      byte_cnt;
  logic [TW-1:0]                   tmo_cnt;
  // Holds data bytes 0..6; byte 7 arrives on the final strobe and goes
  // straight into rsp_data.
  logic [8*(DATA_BYTES-1)-1:0]     data_sh;

  // Send-immediate is never used.
  assign siwu_n    = 1'b1;
  assign dbg_state = state;

  // Single FSM: sequencing, counters and all registered pad/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      byte_cnt  <= '0;
      tmo_cnt   <= '0;
      data_sh   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      adbus_o   <= '0;
      adbus_oe  <= 1'b0;
      wr_n      <= 1'b1;
      oe_n      <= 1'b1;
      rd_n      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          wr_n      <= 1'b1;
          oe_n      <= 1'b1;
          rd_n      <= 1'b1;
          rsp_valid <= 1'b0;
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            adbus_o   <= get_byte(req_addr, 3'd0);
            adbus_oe  <= 1'b1;
            wr_n      <= 1'b0;
            byte_cnt  <= '0;
            req_ready <= 1'b0;
            state     <= ST_WR_ADDR;
          end else begin
            req_ready <= 1'b1;
          end
        end

        ST_WR_ADDR: begin
          if (!wr_n && !txe_n) begin
            // Current byte taken by the device.
            if (byte_cnt == 4'(ADDR_BYTES - 1)) begin
              byte_cnt <= 4'(ADDR_BYTES);
              wr_n     <= 1'b1;
              adbus_oe <= 1'b0;
              tmo_cnt  <= '0;
              state    <= ST_WAIT_RXF;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
              adbus_o  <= get_byte(addr_q, byte_cnt[2:0] + 3'd1);
              wr_n     <= 1'b0;
            end
          end else begin
            // Not taken: hold the byte and strobe only while the FIFO has room.
            wr_n <= txe_n;
          end
        end

        ST_WAIT_RXF: begin
          if (!rxf_n) begin
            oe_n     <= 1'b0;
            rd_n     <= 1'b0;
            byte_cnt <= '0;
            state    <= ST_RD_DATA;
          end else if (tmo_cnt == T_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            state     <= ST_RESP;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_RD_DATA: begin
          // byte_cnt = number of low cycles already completed; the first one
          // is the bus turnaround and carries no data.
          if (byte_cnt != '0) begin
            data_sh <= {adbus_i, data_sh[8*(DATA_BYTES-1)-1:8]};
          end
          if (byte_cnt == 4'(RD_CYCLES - 1)) begin
            oe_n      <= 1'b1;
            rd_n      <= 1'b1;
            byte_cnt  <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= {adbus_i, data_sh};
            state     <= ST_RESP;
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
          end
        end

        ST_RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ft232h_fetch.md
FT232H_FETCH -- requirements
Module: ft232h_fetch

Interface
REQ-001 Parameter: TIMEOUT, 1024, max cycles spent waiting for rxf_n low before the read phase is abandoned.
REQ-002 clk  in  1  FT232H clkout (60 MHz sync-FIFO clock); sole clock.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  fetch request.
REQ-005 req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready at a rising edge.
REQ-006 req_addr  in  64  byte address; sent whole, bits [2:0] are ignored by the device.
REQ-007 rsp_valid  out  1  one-cycle pulse, response available.
REQ-008 rsp_data  out  64  fetched word, byte 0 in [7:0]; held until the next rsp_valid.
REQ-009 rsp_err  out  1  qualifies rsp_valid: timeout, rsp_data = 0.
REQ-010 adbus_i  in  8  FT232H data bus, input half.
REQ-011 adbus_o  out  8  FT232H data bus, output half.
REQ-012 adbus_oe  out  1  drives adbus_o onto the pad.
REQ-013 txe_n  in  1  device can accept writes (low).
REQ-014 wr_n  out  1  write strobe, active-low.
REQ-015 siwu_n  out  1  constant 1.
REQ-016 rxf_n  in  1  device has read data (low).
REQ-017 oe_n  out  1  device output enable, active-low.
REQ-018 rd_n  out  1  read strobe, active-low.

Function
REQ-019 States: IDLE, WR_ADDR, WAIT_RXF, RD_DATA, RESP; all outputs are registered.
REQ-020 IDLE: on accept, latch req_addr and go to WR_ADDR; wr_n, oe_n and rd_n stay high.
REQ-021 WR_ADDR: adbus_oe=1; wr_n=0 for exactly 8 accepted bytes, LSB-first (byte k = addr[8k+7:8k]).
REQ-022 WR_ADDR byte acceptance: a byte counts only at an edge where wr_n==0 and txe_n==0.
REQ-023 WR_ADDR txe_n high: wr_n goes high next cycle and the current byte is held until txe_n returns low.
REQ-024 WR_ADDR exit: after the 8th accepted byte, wr_n=1 and adbus_oe=0 in the very next cycle; the pad is never driven in WAIT_RXF or RD_DATA.
REQ-025 WAIT_RXF: a timeout counter starts at 0; when rxf_n is sampled low, go to RD_DATA.
REQ-026 WAIT_RXF timeout: if the counter reaches TIMEOUT-1 with rxf_n high, go to RESP with rsp_err=1.
REQ-027 RD_DATA strobes: oe_n=rd_n=0 together for exactly 9 consecutive cycles.
REQ-028 RD_DATA capture: byte k (k=0..7) is captured from adbus_i at the rising edge ending the (k+2)-th low cycle; the first low cycle carries no data.
REQ-029 RD_DATA shift: captured bytes shift in LSB-first (byte 0 to [7:0]).
REQ-030 RD_DATA exit: after the 9th low cycle, oe_n=rd_n=1.
REQ-031 rxf_n during RD_DATA: ignored.
REQ-032 RESP: rsp_valid=1 for one cycle with rsp_data and rsp_err, then IDLE.
REQ-033 Responses: exactly one rsp_valid per accepted request.
REQ-034 Backpressure: none; the response consumer is always ready.
REQ-035 Counters: byte counter 4 bits, 0..8; timeout counter $clog2(TIMEOUT) bits, saturating, no wrap.

Reset
REQ-036 rst_n low asynchronously forces IDLE and clears both counters.
REQ-037 Reset output values: wr_n=oe_n=rd_n=siwu_n=1, adbus_oe=0, adbus_o=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0.
REQ-038 req_ready rises the first cycle after reset release.
REQ-039 Reset mid-transfer: the transfer is abandoned with no response; the device side is resynchronised by its own reset.

Structure
REQ-040 Package ft232h_pkg holds the state enum and the localparams ADDR_BYTES=8, DATA_BYTES=8, RD_CYCLES=9.
REQ-041 Single module; no sub-module is needed.
REQ-042 Implementation size: 120-400 lines.

Verification
REQ-043 Fetch at 0x0 against the FT232H behavioural model preloaded with word 0x1122334455667788 -> 8 wr_n-low cycles carrying 00×8, then 9 rd_n-low cycles; rsp_data=0x1122334455667788, rsp_err=0.
REQ-044 Fetch at 0x2000 then 0x2008 back-to-back, with req_valid held -> two responses in order, each matching the model; req_ready low between the two accepts.
REQ-045 Hold txe_n high for 3 cycles after byte 3 -> wr_n high for those cycles, adbus_o holds byte 4, and the device receives exactly 8 bytes.
REQ-046 rxf_n never asserts, TIMEOUT=16 -> rsp_valid with rsp_err=1 and rsp_data=0 exactly 16 cycles after WAIT_RXF entry.
REQ-047 rst_n pulsed low during RD_DATA cycle 4 -> all outputs at reset values immediately; no rsp_valid; the next fetch returns correct data.
REQ-048 Bus-contention assertion on every cycle of all scenarios -> adbus_oe is never 1 while oe_n is 0.
